wb_scheduler: RTL and testbench
===============================

# wb_scheduler

Writeback scheduler between the PE array and the feature RAM (FRAM) write port. It captures result groups pulsed by the decoder's `out_en` into a 2-entry group buffer and serialises them into FRAM. Enabled lanes are written in ascending PE index at consecutive addresses starting from the layer's output base. It drives `wb_busy` back to the decoder for back-pressure. It also arbitrates the single FRAM write port against a host loader, with a starvation guard.

## Interface
- `HOST_STARVE_LIM`, default 16: consecutive ungranted host-request cycles after which the host is forced a slot.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `layer_start` in 1: one-cycle pulse. Loads `output_baseaddr`, flushes the buffer, clears `wb_count` and `overflow`.
- `output_baseaddr` in `FRAM_ADDR_RANGE`: first writeback address, sampled on `layer_start`.
- `out_en` in `PE_NUM`: per-lane result-valid pulse from the decoder.
- `pe_result` in `PE_NUM`*32: lane i data at [i*32 +: 32].
- `wb_busy` out 1: group buffer full; decoder must not pulse `out_en`.
- `host_wr_req` in 1: host write request, held until granted.
- `host_wr_addr` in `FRAM_ADDR_RANGE`: host write address.
- `host_wr_data` in `DATA_RANGE`: host write data.
- `host_wr_gnt` out 1: host write accepted this cycle.
- `fram_we` out 1: registered FRAM write enable.
- `fram_waddr` out `FRAM_ADDR_RANGE`: registered write address.
- `fram_wdata` out `DATA_RANGE`: registered write data.
- `wb_idle` out 1: buffer empty and no write pending in the output register.
- `wb_count` out 32: writeback words issued since the last `layer_start`.
- `overflow` out 1: sticky; a group was dropped.

## Operation
- Group buffer: 2-entry FIFO. Each entry holds a `PE_NUM` lane mask plus `PE_NUM` data words.
  - Capture: `out_en != 0` and the FIFO is not full. Stores `out_en` as the mask and all of `pe_result`.
- Drain (WB slot): on the head entry, pick the lowest set mask bit combinationally.
  - Issue one write: data from that lane, address `wr_ptr`.
  - Clear the bit and increment `wr_ptr` (wraps modulo 2^FRAM address width).
  - Increment `wb_count`.
  - When the last bit clears, pop in the same cycle. The next entry drains from the following cycle, with no bubbles.
- Lane-to-address: lanes are written in ascending order; zero-mask lanes get no address.
- Arbitration, per cycle, in priority order:
  1. Forced host: starvation counter == `HOST_STARVE_LIM` and `host_wr_req`. Host wins the slot; WB stalls one cycle; counter clears.
  2. WB: FIFO non-empty.
  3. Host: `host_wr_req` and FIFO empty. Counter clears.
- Starvation counter increments on each cycle with `host_wr_req` high and no grant, and saturates at `HOST_STARVE_LIM`.
- `host_wr_gnt` is combinational and coincides with the slot. Host writes never touch `wr_ptr` or `wb_count`.
- `wb_busy` is a decode of the registered FIFO count (count == 2).
- `out_en != 0` while full with no pop this cycle: group dropped, `overflow` set.
  - Full with a pop in the same cycle: the capture is accepted.
- `layer_start`: `wr_ptr` loads `output_baseaddr`; FIFO and starvation counter clear; `wb_count` = 0; `overflow` = 0. It has priority over a same-cycle `out_en` capture (dropped, no overflow) and over a drain write (none issued that cycle). A host grant in that cycle still proceeds.

## Timing
- Reset values: `fram_we`=0, `fram_waddr`=0, `fram_wdata`=0, `wb_busy`=0, `host_wr_gnt`=0, `wb_idle`=1, `wb_count`=0, `overflow`=0. Internal `wr_ptr`=0, FIFO empty.
- `out_en` sampled at edge E0: the slot selects the first lane in the cycle after E0, and `fram_*` shows the write after edge E1.
- Full-mask group: `PE_NUM` consecutive `fram_we` cycles.
- Host grant in cycle C: `fram_*` shows the host write after the edge ending C.
- `wb_busy` rises the cycle after the capture that fills the buffer and falls the cycle after the pop.
- Reset asserted mid-drain: all state returns to reset values immediately; pending results are lost.

## Test plan
- Full-mask group: `layer_start` with base 0x100, `out_en`=4'b1111, data 0xA0..0xA3. Required: writes 0x100←0xA0 through 0x103←0xA3 on 4 consecutive cycles, then `wb_count`=4, `wb_idle`=1.
- Sparse mask: `out_en`=4'b1010 then 4'b0001 back-to-back. Required: addresses base, base+1, base+2 get lane1, lane3, lane0, with no idle cycle between them.
- Overflow: three full-mask groups on consecutive cycles. Required: `wb_busy` high after the 2nd capture, the 3rd group is dropped, `overflow`=1, and exactly 8 writes occur.
- Host-only: `host_wr_req` with 0x20/0xDEAD while the FIFO is empty. Required: same-cycle `host_wr_gnt`, a single write 0x20←0xDEAD, and the next WB address unchanged.
- Host starvation: `host_wr_req` held during continuous WB traffic. Required: grant on the 17th request cycle, one WB stall cycle, and all WB words still written in order.
- Mid-drain abort: `layer_start` (base 0x300) during a drain, same cycle as an `out_en`. Required: no further old writes, the `out_en` group dropped, `overflow`=0, and the next group writes at 0x300.

Source files
------------

// File: rtl/wb_scheduler.sv
// wb_scheduler: buffers PE result groups in a 2-entry FIFO and serialises
// them into the FRAM write port, sharing the port with a host loader.
module wb_scheduler #(
  parameter int PE_NUM          = 4,
  parameter int ADDR_W          = 12,
  parameter int DATA_W          = 32,
  parameter int HOST_STARVE_LIM = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     layer_start,
  input  logic [ADDR_W-1:0]        output_baseaddr,
  input  logic [PE_NUM-1:0]        out_en,
  input  logic [PE_NUM*DATA_W-1:0] pe_result,
  output logic                     wb_busy,
  input  logic                     host_wr_req,
  input  logic [ADDR_W-1:0]        host_wr_addr,
  input  logic [DATA_W-1:0]        host_wr_data,
  output logic                     host_wr_gnt,
  output logic                     fram_we,
  output logic [ADDR_W-1:0]        fram_waddr,
  output logic [DATA_W-1:0]        fram_wdata,
  output logic                     wb_idle,
  output logic [31:0]              wb_count,
  output logic                     overflow
);

  localparam int SW = $clog2(HOST_STARVE_LIM + 1);
  localparam int LW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

  logic [PE_NUM-1:0]        r_mask [2];
  logic [PE_NUM*DATA_W-1:0] r_data [2];
  logic                     r_head;
  logic                     r_tail;
  logic [1:0]               r_cnt;
  logic [ADDR_W-1:0]        r_wr_ptr;
  logic [SW-1:0]            r_starve;
  logic [31:0]              r_wb_count;
  logic                     r_ovf;
  logic                     r_we;
  logic [ADDR_W-1:0]        r_waddr;
  logic [DATA_W-1:0]        r_wdata;

  logic              w_empty;
  logic              w_full;
  logic [PE_NUM-1:0] w_hmask;
  logic [PE_NUM-1:0] w_low;
  logic [LW-1:0]     w_lane;
  logic [DATA_W-1:0] w_lane_data;
  logic              w_force;
  logic              w_wb_slot;
  logic              w_wb_wr;
  logic              w_last;
  logic              w_pop;
  logic              w_has;
  logic              w_cap;
  logic              w_drop;

  assign w_empty = (r_cnt == 2'd0);
  assign w_full  = (r_cnt == 2'd2);
  assign w_hmask = r_mask[r_head];
  assign w_low   = w_hmask & ~(w_hmask - PE_NUM'(1));

  always_comb begin
    w_lane = '0;
    for (int i = PE_NUM - 1; i >= 0; i--)
      if (w_hmask[i]) w_lane = LW'(i);
  end

  assign w_lane_data = r_data[r_head][w_lane*DATA_W +: DATA_W];

  // Forced host slot beats WB; otherwise host only gets an empty FIFO.
  assign w_force     = (r_starve == SW'(HOST_STARVE_LIM)) && host_wr_req;
  assign w_wb_slot   = !w_force && !w_empty;
  assign w_wb_wr     = w_wb_slot && !layer_start;
  assign host_wr_gnt = w_force || (host_wr_req && w_empty);

  assign w_last = ((w_hmask & ~w_low) == '0);
  assign w_pop  = w_wb_wr && w_last;
  assign w_has  = |out_en;
  assign w_cap  = w_has && (!w_full || w_pop) && !layer_start;
  assign w_drop = w_has && w_full && !w_pop && !layer_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mask[i] <= '0;
        r_data[i] <= '0;
      end
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= 2'd0;
      r_wr_ptr   <= '0;
      r_wb_count <= '0;
      r_ovf      <= 1'b0;
    end else if (layer_start) begin
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= 2'd0;
      r_wr_ptr   <= output_baseaddr;
      r_wb_count <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wb_wr) begin
        r_mask[r_head] <= w_hmask & ~w_low;
        r_wr_ptr       <= r_wr_ptr + ADDR_W'(1);
        r_wb_count     <= r_wb_count + 32'd1;
      end
      if (w_pop)
        r_head <= ~r_head;
      // On full+pop the tail aliases the head; the capture wins.
      if (w_cap) begin
        r_mask[r_tail] <= out_en;
        r_data[r_tail] <= pe_result;
        r_tail         <= ~r_tail;
      end
      unique case ({w_cap, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_starve <= '0;
    else if (layer_start || host_wr_gnt)
      r_starve <= '0;
    else if (host_wr_req && (r_starve != SW'(HOST_STARVE_LIM)))
      r_starve <= r_starve + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_wb_wr || host_wr_gnt;
      unique case (1'b1)
        host_wr_gnt: begin
          r_waddr <= host_wr_addr;
          r_wdata <= host_wr_data;
        end
        w_wb_wr: begin
          r_waddr <= r_wr_ptr;
          r_wdata <= w_lane_data;
        end
        default: ;
      endcase
    end
  end

  assign fram_we    = r_we;
  assign fram_waddr = r_waddr;
  assign fram_wdata = r_wdata;
  assign wb_busy    = w_full;
  assign wb_idle    = w_empty && !r_we;
  assign wb_count   = r_wb_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_wb_scheduler.sv
// tb_wb_scheduler: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the writeback scheduler.
module tb_wb_scheduler;

  localparam int PE  = 4;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           layer_start = 1'b0;
  logic [AW-1:0]  output_baseaddr = '0;
  logic [PE-1:0]  out_en = '0;
  logic [PE*DW-1:0] pe_result = '0;
  logic           wb_busy;
  logic           host_wr_req = 1'b0;
  logic [AW-1:0]  host_wr_addr = '0;
  logic [DW-1:0]  host_wr_data = '0;
  logic           host_wr_gnt;
  logic           fram_we;
  logic [AW-1:0]  fram_waddr;
  logic [DW-1:0]  fram_wdata;
  logic           wb_idle;
  logic [31:0]    wb_count;
  logic           overflow;

  always #5 clk = ~clk;

  wb_scheduler #(
    .PE_NUM(PE), .ADDR_W(AW), .DATA_W(DW), .HOST_STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .layer_start(layer_start),
    .output_baseaddr(output_baseaddr), .out_en(out_en),
    .pe_result(pe_result), .wb_busy(wb_busy),
    .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_wr_gnt(host_wr_gnt),
    .fram_we(fram_we), .fram_waddr(fram_waddr), .fram_wdata(fram_wdata),
    .wb_idle(wb_idle), .wb_count(wb_count), .overflow(overflow)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: words waiting in FIFO order, plus words left per buffered group.
  logic [DW-1:0] m_wq[$];
  int            m_gl[$];
  logic [AW-1:0] m_ptr;
  int unsigned   m_cnt;
  bit            m_ovf;
  int            m_starve;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  typedef struct packed {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wlog[$];
  bit  last_gnt;

  task automatic m_reset();
    m_wq.delete();
    m_gl.delete();
    m_ptr = '0; m_cnt = 0; m_ovf = 0; m_starve = 0;
    m_we = 0; m_addr = '0; m_data = '0;
  endtask

  always @(negedge clk) begin
    bit forced, wbs, g, pop, full;
    int n;
    cyc++;
    if (!rst_n) m_reset();
    forced = (m_starve == LIM) && host_wr_req;
    wbs    = !forced && (m_gl.size() > 0);
    g      = forced || (host_wr_req && m_gl.size() == 0);
    check("gnt", host_wr_gnt, g);
    check("busy", wb_busy, m_gl.size() == 2);
    check("idle", wb_idle, (m_gl.size() == 0) && !m_we);
    check("we", fram_we, m_we);
    if (m_we) begin
      check("waddr", fram_waddr, m_addr);
      check("wdata", fram_wdata, m_data);
    end
    check("count", wb_count, m_cnt);
    check("ovf", overflow, m_ovf);
    if (fram_we && rst_n) wlog.push_back('{cyc, fram_waddr, fram_wdata});
    last_gnt = host_wr_gnt;
    if (rst_n) begin
      full = (m_gl.size() == 2);
      pop  = 0;
      m_we = 0;
      if (g) begin
        m_we = 1; m_addr = host_wr_addr; m_data = host_wr_data;
      end
      if (layer_start) begin
        m_wq.delete(); m_gl.delete();
        m_ptr = output_baseaddr; m_cnt = 0; m_ovf = 0;
      end else begin
        if (wbs) begin
          m_we = 1; m_addr = m_ptr; m_data = m_wq.pop_front();
          m_ptr++; m_cnt++;
          m_gl[0] = m_gl[0] - 1;
          if (m_gl[0] == 0) begin
            void'(m_gl.pop_front());
            pop = 1;
          end
        end
        if (out_en != '0) begin
          if (!full || pop) begin
            n = 0;
            for (int i = 0; i < PE; i++)
              if (out_en[i]) begin
                m_wq.push_back(pe_result[i*DW +: DW]);
                n++;
              end
            m_gl.push_back(n);
          end else begin
            m_ovf = 1;
          end
        end
      end
      if (layer_start || g) m_starve = 0;
      else if (host_wr_req && m_starve < LIM) m_starve++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(logic [PE-1:0] m, logic [DW-1:0] b);
    out_en = m;
    for (int i = 0; i < PE; i++) pe_result[i*DW +: DW] = b + DW'(i);
  endtask

  task automatic group(logic [PE-1:0] m, logic [DW-1:0] b);
    set_group(m, b);
    tick();
    out_en = '0;
  endtask

  task automatic lstart(logic [AW-1:0] base);
    layer_start = 1'b1;
    output_baseaddr = base;
    tick();
    layer_start = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (!wb_idle && t < 300);
    check({nm, "_idle_timeout"}, wb_idle, 1);
  endtask

  logic [DW-1:0] fed[$];
  int got;
  int hosts;
  int wbi;

  initial begin
    repeat (2) tick();
    check("rst_idle", wb_idle, 1);
    check("rst_we", fram_we, 0);
    check("rst_count", wb_count, 0);
    rst_n = 1'b1;
    tick();

    // Full-mask group
    lstart(12'h100);
    wlog.delete();
    group(4'hF, 32'hA0);
    wait_idle("full");
    check("full_n", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++) begin
      check("full_addr", wlog[i].a, 12'h100 + i);
      check("full_data", wlog[i].d, 32'hA0 + i);
      check("full_cyc", wlog[i].c, wlog[0].c + i);
    end
    check("full_count", wb_count, 4);

    // Sparse masks back-to-back
    lstart(12'h040);
    wlog.delete();
    group(4'b1010, 32'hB0);
    group(4'b0001, 32'hC0);
    wait_idle("sparse");
    check("sparse_n", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("sp0", {wlog[0].a, wlog[0].d}, {12'h040, 32'hB1});
      check("sp1", {wlog[1].a, wlog[1].d}, {12'h041, 32'hB3});
      check("sp2", {wlog[2].a, wlog[2].d}, {12'h042, 32'hC0});
      check("sp_gap", wlog[2].c, wlog[0].c + 2);
    end

    // Overflow
    lstart(12'h200);
    wlog.delete();
    set_group(4'hF, 32'hD0);
    tick();
    set_group(4'hF, 32'hE0);
    tick();
    check("ovf_busy", wb_busy, 1);
    set_group(4'hF, 32'hF0);
    tick();
    out_en = '0;
    wait_idle("ovf");
    check("ovf_flag", overflow, 1);
    check("ovf_n", wlog.size(), 8);
    if (wlog.size() == 8)
      check("ovf_last", {wlog[7].a, wlog[7].d}, {12'h207, 32'hE3});

    // Host-only write leaves wr_ptr alone
    wlog.delete();
    host_wr_req = 1'b1; host_wr_addr = 12'h020; host_wr_data = 32'hDEAD;
    #1;
    check("host_gnt", host_wr_gnt, 1);
    tick();
    host_wr_req = 1'b0;
    group(4'b0001, 32'h70);
    wait_idle("host");
    check("host_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("host_wr", {wlog[0].a, wlog[0].d}, {12'h020, 32'hDEAD});
      check("host_next", {wlog[1].a, wlog[1].d}, {12'h208, 32'h70});
    end

    // Host starvation under continuous WB traffic
    lstart(12'h000);
    wlog.delete();
    fed.delete();
    set_group(4'hF, 32'h1000);
    for (int i = 0; i < PE; i++) fed.push_back(32'h1000 + i);
    tick();
    got = 0;
    for (int k = 1; k <= 100 && got == 0; k++) begin
      host_wr_req = 1'b1; host_wr_addr = 12'h3FF; host_wr_data = 32'hBEEF;
      if (!wb_busy) begin
        set_group(4'hF, 32'h1000 + k * 16);
        for (int i = 0; i < PE; i++) fed.push_back(32'h1000 + k * 16 + i);
      end else begin
        out_en = '0;
      end
      #1;
      if (host_wr_gnt) got = k;
      tick();
    end
    host_wr_req = 1'b0;
    out_en = '0;
    check("starve_gnt_cycle", got, 17);
    wait_idle("starve");
    hosts = 0;
    wbi = 0;
    foreach (wlog[i]) begin
      check("starve_cyc", wlog[i].c, wlog[0].c + i);
      if (wlog[i].a == 12'h3FF) begin
        hosts++;
      end else begin
        check("starve_wb_addr", wlog[i].a, wbi);
        check("starve_wb_data", wlog[i].d, (wbi < fed.size()) ? fed[wbi] : 32'hX);
        wbi++;
      end
    end
    check("starve_hosts", hosts, 1);
    check("starve_words", wbi, fed.size());

    // Mid-drain abort
    lstart(12'h100);
    group(4'hF, 32'h50);
    tick();
    layer_start = 1'b1; output_baseaddr = 12'h300;
    set_group(4'hF, 32'h60);
    tick();
    layer_start = 1'b0;
    out_en = '0;
    wlog.delete();
    repeat (3) tick();
    check("abort_nowr", wlog.size(), 0);
    check("abort_ovf", overflow, 0);
    check("abort_idle", wb_idle, 1);
    group(4'b0011, 32'h80);
    wait_idle("abort");
    check("abort_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("abort_w0", {wlog[0].a, wlog[0].d}, {12'h300, 32'h80});
      check("abort_w1", {wlog[1].a, wlog[1].d}, {12'h301, 32'h81});
    end

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        host_wr_req = 1'b0;
      end
      layer_start = ($urandom_range(0, 149) == 0);
      output_baseaddr = AW'($urandom);
      if ($urandom_range(0, 9) < 4) out_en = PE'($urandom);
      else out_en = '0;
      for (int i = 0; i < PE; i++) pe_result[i*DW +: DW] = $urandom;
      if (rst_n) begin
        if (host_wr_req && last_gnt) host_wr_req = 1'b0;
        if (!host_wr_req && $urandom_range(0, 9) == 0) begin
          host_wr_req = 1'b1;
          host_wr_addr = AW'($urandom);
          host_wr_data = $urandom;
        end
      end
      tick();
    end
    rst_n = 1'b1;
    layer_start = 1'b0;
    out_en = '0;
    host_wr_req = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
